// File: rtl/prm_edge_chk_engine_pkg.sv
// Shared types and helpers for the PRM edge-check engine: FSM state, default
// table geometry and a popcount used for the blocked-edge total.
package prm_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int PRM_OCC_W    = 15;
    localparam int PRM_EDGE_NUM = 64;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prm_edge_chk_engine_if.sv
// Query/result stream bundle between the voxeliser, the engine and the edge filter.
// Both channels: a beat transfers on a rising edge where valid & ready are high;
// the sender keeps valid and its payload stable until that edge.
interface prm_edge_chk_engine_if #(
    parameter int OCC_W = 15,
    parameter int LANES = 4,
    parameter int AW    = 6
);
    logic             occ_valid;
    logic             occ_ready;
    logic [OCC_W-1:0] occ_data;
    logic             res_valid;
    logic             res_ready;
    logic [LANES-1:0] res_mask;
    logic [AW-1:0]    res_idx;
    logic             res_last;
    logic [AW:0]      res_blk_cnt;

    modport master (
        output occ_valid, occ_data, res_ready,
        input  occ_ready, res_valid, res_mask, res_idx, res_last, res_blk_cnt
    );

    modport slave (
        input  occ_valid, occ_data, res_ready,
        output occ_ready, res_valid, res_mask, res_idx, res_last, res_blk_cnt
    );
endinterface

// File: rtl/prm_edge_chk_engine_lane.sv
// One edge evaluator: the edge is blocked when any voxel it sweeps is occupied.
module prm_edge_lane #(
    parameter int OCC_W = 15
) (
    input  logic [OCC_W-1:0] occ,
    input  logic [OCC_W-1:0] mask,
    output logic             blocked
);
    assign blocked = |(occ & mask);
endmodule

// File: rtl/prm_edge_chk_engine.sv
// Reloadable swept-voxel table; each occupancy query streams back LANES
// blocked/free bits per beat plus the total blocked count on the last beat.
module prm_edge_chk_engine
    import prm_chk_pkg::*;
#(
    parameter int OCC_W    = PRM_OCC_W,
    parameter int EDGE_NUM = PRM_EDGE_NUM,
    parameter int LANES    = 4,
    parameter int AW       = $clog2(EDGE_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [OCC_W-1:0] cfg_data,
    output logic             cfg_busy,
    output logic             cfg_err,
    output state_t           state_dbg,
    prm_edge_chk_engine_if.slave bus
);
    localparam int            BEATS    = EDGE_NUM / LANES;
    localparam logic [AW-1:0] LAST_IDX = AW'(BEATS - 1);

    state_t           state_q, state_d;
    logic [OCC_W-1:0] tbl [EDGE_NUM];
    logic [OCC_W-1:0] occ_q;
    logic [AW-1:0]    beat_q;
    logic [AW:0]      acc_q;
    logic             res_valid_q;
    logic [LANES-1:0] mask_q;
    logic             last_q;
    logic [AW:0]      blk_q;
    logic             cfg_err_q;

    logic             wr_ok;
    logic             q_accept;
    logic             beat_accept;
    logic [AW-1:0]    eval_beat;
    logic [OCC_W-1:0] eval_occ;
    logic [LANES-1:0] eval_mask;
    logic [AW:0]      eval_cnt;
    logic [AW:0]      acc_next;
    logic             next_is_last;

    assign wr_ok       = cfg_we && (state_q == IDLE) && ({1'b0, cfg_addr} < (AW+1)'(EDGE_NUM));
    assign q_accept    = (state_q == IDLE) && bus.occ_valid;
    assign beat_accept = res_valid_q && bus.res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.occ_valid) state_d = SCAN;
            SCAN:    if (beat_accept && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the beat being prepared is beat 0 of the incoming query;
    // in SCAN it is the beat after the one currently presented.
    always_comb begin
        eval_beat = '0;
        eval_occ  = occ_q;
        if (state_q == IDLE) eval_occ = bus.occ_data;
        else if (beat_q != LAST_IDX) eval_beat = beat_q + AW'(1);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [AW-1:0]    idx;
        logic [OCC_W-1:0] ent;
        assign idx = eval_beat * AW'(LANES) + AW'(i);
        // Forward a same-cycle write so it is seen by a query accepted alongside it.
        assign ent = (wr_ok && cfg_addr == idx) ? cfg_data : tbl[idx];
        prm_edge_lane #(.OCC_W(OCC_W)) u_lane (
            .occ     (eval_occ),
            .mask    (ent),
            .blocked (eval_mask[i])
        );
    end

    assign eval_cnt     = (AW+1)'(popcount(32'(eval_mask)));
    assign acc_next     = acc_q + (AW+1)'(popcount(32'(mask_q)));
    assign next_is_last = ((beat_q + AW'(1)) == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < EDGE_NUM; e++) tbl[e] <= '0;
        end else if (wr_ok) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q       <= '0;
            beat_q      <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            mask_q      <= '0;
            last_q      <= 1'b0;
            blk_q       <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            if (cfg_we && !wr_ok) cfg_err_q <= 1'b1;
            if (q_accept) begin
                occ_q       <= bus.occ_data;
                beat_q      <= '0;
                acc_q       <= '0;
                res_valid_q <= 1'b1;
                mask_q      <= eval_mask;
                last_q      <= (BEATS == 1);
                blk_q       <= (BEATS == 1) ? eval_cnt : '0;
            end else if (state_q == SCAN && beat_accept) begin
                if (last_q) begin
                    res_valid_q <= 1'b0;
                    beat_q      <= '0;
                    mask_q      <= '0;
                    last_q      <= 1'b0;
                    blk_q       <= '0;
                end else begin
                    acc_q  <= acc_next;
                    beat_q <= beat_q + AW'(1);
                    mask_q <= eval_mask;
                    last_q <= next_is_last;
                    blk_q  <= next_is_last ? (acc_next + eval_cnt) : '0;
                end
            end
        end
    end

    assign bus.occ_ready   = (state_q == IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_mask    = mask_q;
    assign bus.res_idx     = beat_q;
    assign bus.res_last    = last_q;
    assign bus.res_blk_cnt = blk_q;
    assign cfg_busy        = (state_q != IDLE);
    assign cfg_err         = cfg_err_q;
    assign state_dbg       = state_q;
endmodule
